// File: rtl/flags_pkg.sv
// Shared flag indices and the flag word type for the condition-flag unit.
// Bit order of flags_t matches flag_mask and flags_out: {C,O,S,Z}.
package flags_pkg;
    localparam int NUM_FLAGS = 4;
    localparam int FLAG_Z    = 0;
    localparam int FLAG_S    = 1;
    localparam int FLAG_O    = 2;
    localparam int FLAG_C    = 3;

    typedef logic [NUM_FLAGS-1:0] flags_t;
endpackage

// File: rtl/flags_stack.sv
// LIFO of flag words with depth counter, full/empty decodes and a one-cycle error pulse.
// Push/pop take effect on the next edge; simultaneous push+pop is a no-op, overflow/underflow only pulse err_pulse.
module flags_stack
    import flags_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [NUM_FLAGS-1:0] push_dat,
    output logic [NUM_FLAGS-1:0] pop_dat,
    output logic                 pop_vld,
    output logic [CNT_W-1:0]     depth,
    output logic                 full,
    output logic                 empty,
    output logic                 err_pulse
);
    flags_t           stack_q [STACK_DEPTH];
    flags_t           stack_d [STACK_DEPTH];
    logic [CNT_W-1:0] depth_q;
    logic [CNT_W-1:0] depth_d;
    logic             do_push;

    assign full      = (depth_q == CNT_W'(STACK_DEPTH));
    assign empty     = (depth_q == '0);
    assign do_push   = push & ~pop & ~full;
    assign pop_vld   = pop & ~push & ~empty;
    assign err_pulse = (push & ~pop & full) | (pop & ~push & empty);
    assign depth     = depth_q;

    always_comb begin
        depth_d = depth_q;
        stack_d = stack_q;
        pop_dat = '0;
        // Compare against depth instead of indexing with it, so the counter width never has to match the array.
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (do_push && (depth_q == CNT_W'(i))) stack_d[i] = push_dat;
            if (depth_q == CNT_W'(i + 1)) pop_dat = stack_q[i];
        end
        if (do_push)      depth_d = depth_q + CNT_W'(1);
        else if (pop_vld) depth_d = depth_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) depth_q <= '0;
        else       depth_q <= depth_d;
    end

    // Storage needs no reset: entries above depth are never read.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end
endmodule

// File: rtl/flags_unit.sv
// Registered Z/S/O/C flags with per-flag write mask and a save/restore stack; 1-cycle latency, no backpressure.
// Optional sticky overflow (so/so_clr) under `FLAGS_STICKY_OVF_EN.
module flags_unit
    import flags_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flags_write,
    input  logic [NUM_FLAGS-1:0] flag_mask,
    input  logic [DATA_W-1:0]    result,
    input  logic                 carry_in,
    input  logic                 ovf_in,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 err_clr,
`ifdef FLAGS_STICKY_OVF_EN
    input  logic                 so_clr,
    output logic                 so,
`endif
    output logic                 zf,
    output logic                 sf,
    output logic                 of,
    output logic                 cf,
    output logic [NUM_FLAGS-1:0] flags_out,
    output logic [CNT_W-1:0]     depth,
    output logic                 stack_full,
    output logic                 stack_empty,
    output logic                 stack_err
);
    flags_t flags_q;
    flags_t flags_d;
    flags_t nxt_flags;
    flags_t pop_dat;
    logic   pop_vld;
    logic   err_pulse;
    logic   err_q;
    logic   err_d;

    flags_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_W       (CNT_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_dat  (flags_q),
        .pop_dat   (pop_dat),
        .pop_vld   (pop_vld),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty),
        .err_pulse (err_pulse)
    );

    always_comb begin
        nxt_flags         = '0;
        nxt_flags[FLAG_Z] = (result == '0);
        nxt_flags[FLAG_S] = result[DATA_W-1];
        nxt_flags[FLAG_O] = ovf_in;
        nxt_flags[FLAG_C] = carry_in;

        // A successful pop restores the whole word; the masked write is dropped.
        flags_d = flags_q;
        if (pop_vld)          flags_d = pop_dat;
        else if (flags_write) flags_d = (flags_q & ~flag_mask) | (nxt_flags & flag_mask);

        err_d = err_q;
        if (err_pulse)    err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

`ifdef FLAGS_STICKY_OVF_EN
    logic so_q;
    logic so_d;
    logic so_set;

    always_comb begin
        so_set = pop_vld ? pop_dat[FLAG_O] : (flags_write & flag_mask[FLAG_O] & ovf_in);
        so_d   = so_q;
        if (so_set)      so_d = 1'b1;
        else if (so_clr) so_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) so_q <= 1'b0;
        else       so_q <= so_d;
    end

    assign so = so_q;
`endif

    assign zf        = flags_q[FLAG_Z];
    assign sf        = flags_q[FLAG_S];
    assign of        = flags_q[FLAG_O];
    assign cf        = flags_q[FLAG_C];
    assign flags_out = flags_q;
    assign stack_err = err_q;
endmodule
